// File: rtl/boot_pkg.sv
// Shared types and width helpers for the boot loader and its counters.
package boot_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_IMEM,
    ST_RF,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  function automatic int ia_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int ra_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int cw_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/boot_ctr.sv
// Loadable up-counter with a terminal-count flag (count equals i_term).
module boot_ctr #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en)   r_cnt <= r_cnt + W'(1);
  end

  assign o_count = r_cnt;
  assign o_tc    = (r_cnt == i_term);

endmodule

// File: rtl/boot_loader.sv
// Stream-driven program loader and run controller for the core.
// Optional macro BOOT_REG_IDENTITY_EN: register file is filled with rf[j]=j instead of stream beats.
module boot_loader
  import boot_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMEM_DEPTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int RUN_CYCLES = 100,
  localparam int IA_W = ia_w(IMEM_DEPTH),
  localparam int RA_W = ra_w(REG_COUNT),
  localparam int CW   = cw_w(RUN_CYCLES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_imem_we,
  output logic [IA_W-1:0]       o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_rf_we,
  output logic [RA_W-1:0]       o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_core_rst_n,
  output logic                  o_core_run,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [CW-1:0]         o_cycle_cnt
);

  localparam int WW = (IA_W > RA_W) ? IA_W : RA_W;
  localparam logic [DATA_WIDTH-1:0] DEPTH_D = DATA_WIDTH'(IMEM_DEPTH);

  boot_state_e     r_state, w_next;
  logic [IA_W-1:0] r_nm1;
  logic [WW-1:0]   w_word, w_word_term;
  logic            w_word_tc, w_word_load, w_word_step;
  logic            w_run_tc, w_acc, w_hdr_ok, w_start_ok, w_rf_step;

  assign w_acc      = i_in_valid & o_in_ready;
  assign w_hdr_ok   = (i_in_data != '0) && (i_in_data <= DEPTH_D);
  assign w_start_ok = i_start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);

`ifdef BOOT_REG_IDENTITY_EN
  assign w_rf_step = (r_state == ST_RF);
`else
  assign w_rf_step = (r_state == ST_RF) && w_acc;
`endif

  // One index counter serves both the instruction and register phases
  assign w_word_term = (r_state == ST_IMEM) ? WW'(r_nm1) : WW'(REG_COUNT - 1);
  assign w_word_step = ((r_state == ST_IMEM) && w_acc) || w_rf_step;
  assign w_word_load = w_start_ok || ((r_state == ST_IMEM) && w_acc && w_word_tc);

  boot_ctr #(.W(WW)) u_word_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_word_load),
    .i_load_val ('0),
    .i_en       (w_word_step),
    .i_term     (w_word_term),
    .o_count    (w_word),
    .o_tc       (w_word_tc)
  );

  boot_ctr #(.W(CW)) u_run_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_start_ok),
    .i_load_val ('0),
    .i_en       (r_state == ST_RUN),
    .i_term     (CW'(RUN_CYCLES - 1)),
    .o_count    (o_cycle_cnt),
    .o_tc       (w_run_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (i_start) w_next = ST_HDR;
      ST_HDR:  if (w_acc) w_next = w_hdr_ok ? ST_IMEM : ST_ERR;
      ST_IMEM: if (w_acc && w_word_tc) w_next = ST_RF;
      ST_RF:   if (w_rf_step && w_word_tc) w_next = ST_RUN;
      ST_RUN:  if (w_run_tc) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready   = 1'b0;
    o_core_rst_n = 1'b0;
    o_core_run   = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      ST_HDR, ST_IMEM: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
      end
      ST_RF: begin
`ifdef BOOT_REG_IDENTITY_EN
        o_in_ready = 1'b0;
`else
        o_in_ready = 1'b1;
`endif
        o_busy     = 1'b1;
      end
      ST_RUN: begin
        o_core_rst_n = 1'b1;
        o_core_run   = 1'b1;
        o_busy       = 1'b1;
      end
      ST_DONE: begin
        o_core_rst_n = 1'b1;
        o_done       = 1'b1;
      end
      ST_ERR:  o_err = 1'b1;
      default: ;
    endcase
  end

  // Write ports are registered: strobe appears the cycle after the beat/step
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nm1        <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_rf_we      <= 1'b0;
      o_rf_addr    <= '0;
      o_rf_wdata   <= '0;
    end else begin
      o_imem_we <= (r_state == ST_IMEM) && w_acc;
      o_rf_we   <= w_rf_step;
      if ((r_state == ST_HDR) && w_acc) r_nm1 <= i_in_data[IA_W-1:0] - 1'b1;
      if ((r_state == ST_IMEM) && w_acc) begin
        o_imem_addr  <= w_word[IA_W-1:0];
        o_imem_wdata <= i_in_data;
      end
      if (w_rf_step) begin
        o_rf_addr  <= w_word[RA_W-1:0];
`ifdef BOOT_REG_IDENTITY_EN
        o_rf_wdata <= DATA_WIDTH'(w_word[RA_W-1:0]);
`else
        o_rf_wdata <= i_in_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued by the stimulus and checked by a monitor.
module tb_boot_loader;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int RC    = 32;
  localparam int RUNC  = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          o_in_ready, o_imem_we, o_rf_we, o_core_rst_n, o_core_run;
  logic          o_busy, o_done, o_err;
  logic [5:0]    o_imem_addr;
  logic [4:0]    o_rf_addr;
  logic [DW-1:0] o_imem_wdata, o_rf_wdata;
  logic [6:0]    o_cycle_cnt;

  boot_loader #(
    .DATA_WIDTH (DW),
    .IMEM_DEPTH (DEPTH),
    .REG_COUNT  (RC),
    .RUN_CYCLES (RUNC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (o_in_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_rf_we      (o_rf_we),
    .o_rf_addr    (o_rf_addr),
    .o_rf_wdata   (o_rf_wdata),
    .o_core_rst_n (o_core_rst_n),
    .o_core_run   (o_core_run),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_cycle_cnt  (o_cycle_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_rf;
    int unsigned addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (o_imem_we || o_rf_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual imem_we=%0b rf_we=%0b required no write",
                 o_imem_we, o_rf_we);
      end else begin
        e = q.pop_front();
        chk("write_kind", {o_imem_we, o_rf_we}, e.is_rf ? 32'd1 : 32'd2);
        chk("write_addr", e.is_rf ? 32'(o_rf_addr) : 32'(o_imem_addr), e.addr);
        chk("write_data", e.is_rf ? o_rf_wdata : o_imem_wdata, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!o_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=not_ready required=ready");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_prog(input int n, input logic [31:0] base, input bit gap);
    pulse_start();
    chk("hdr_ready", o_in_ready, 1);
    chk("hdr_busy", o_busy, 1);
    beat(n);
    for (int k = 0; k < n; k++) begin
      q.push_back('{is_rf: 1'b0, addr: k, data: base + k});
      beat(base + k);
      if (gap && k < n - 1) @(negedge clk);
    end
  endtask

  task automatic load_rf();
`ifdef BOOT_REG_IDENTITY_EN
    int n = 0;
    for (int j = 0; j < RC; j++) q.push_back('{is_rf: 1'b1, addr: j, data: 32'(j)});
    chk("rf_in_ready", o_in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    while (!o_core_run && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("rf_gen_cycles", n, RC);
`else
    chk("rf_in_ready", o_in_ready, 1);
    for (int j = 0; j < RC; j++) begin
      q.push_back('{is_rf: 1'b1, addr: j, data: 32'h100 + j});
      beat(32'h100 + j);
    end
`endif
    chk("run_core_rst_n", o_core_rst_n, 1);
    chk("run_core_run", o_core_run, 1);
    chk("run_cnt_start", o_cycle_cnt, 0);
  endtask

  task automatic run_to_done(input int already);
    int n = already;
    while (!o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("run_cycles", n, RUNC);
    chk("cycle_cnt_done", o_cycle_cnt, RUNC);
    chk("core_run_done", o_core_run, 0);
    chk("core_rst_done", o_core_rst_n, 1);
    @(negedge clk);
    chk("cycle_cnt_frozen", o_cycle_cnt, RUNC);
    chk("done_held", o_done, 1);
  endtask

  initial begin
    // Reset with start asserted: reset must win
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {o_in_ready, o_imem_we, o_rf_we, o_core_rst_n,
                       o_core_run, o_busy, o_done, o_err}, 0);
    chk("reset_cnt", o_cycle_cnt, 0);
    chk("reset_data", o_imem_wdata | o_rf_wdata | 32'(o_imem_addr) | 32'(o_rf_addr), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {o_busy, o_in_ready}, 0);

    // Reset in the middle of an instruction load
    pulse_start();
    beat(5);
    for (int k = 0; k < 3; k++) begin
      q.push_back('{is_rf: 1'b0, addr: k, data: 32'h50 + k});
      beat(32'h50 + k);
    end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h77;
    @(negedge clk);
    chk("midreset_ctrl", {o_in_ready, o_imem_we, o_rf_we, o_core_rst_n,
                          o_core_run, o_busy, o_done, o_err}, 0);
    chk("midreset_addr", o_imem_addr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("midreset_idle", {o_busy, o_in_ready, o_imem_we}, 0);
    chk("midreset_q_empty", q.size(), 0);

    // Illegal headers
    pulse_start();
    beat(0);
    chk("err_n0", o_err, 1);
    chk("err_n0_core_rst", o_core_rst_n, 0);
    chk("err_n0_busy", o_busy, 0);
    pulse_start();
    chk("err_exit", o_err, 0);
    beat(65);
    chk("err_n65", o_err, 1);
    chk("err_n65_core_rst", o_core_rst_n, 0);

    // Recovery from ERR: full back-to-back load
    load_prog(4, 32'hA0, 1'b0);
    load_rf();
    run_to_done(0);

    // Full-depth load with gaps, start pulsed during RUN
    load_prog(DEPTH, 32'hC000, 1'b1);
    load_rf();
    repeat (10) @(negedge clk);
    chk("cnt_before_start", o_cycle_cnt, 10);
    pulse_start();
    chk("cnt_after_start", o_cycle_cnt, 11);
    chk("busy_after_start", {o_busy, o_core_run, o_in_ready}, 3'b110);
    run_to_done(11);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
